// File: rtl/column_arbiter_wrr.sv
// Weighted round-robin column arbiter for one selected pixel row.
// Grants one requesting column at a time; each column may hold the grant for up to wgt+1 accepts per turn.
module column_arbiter_wrr #(
  parameter int Lvl_COLS    = 8,
  parameter int Lvl_COL_ADD = 3,
  parameter int WGT_W       = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      enable_i,
  input  logic                      wrap_i,
  input  logic [Lvl_COLS-1:0]       req_i,
  input  logic [Lvl_COLS*WGT_W-1:0] wgt_i,
  output logic [Lvl_COLS-1:0]       gnt_o,
  output logic                      gnt_valid_o,
  input  logic                      gnt_ready_i,
  output logic [Lvl_COL_ADD-1:0]    yadd_o,
  output logic                      grp_release_o
);

  typedef enum logic [1:0] {IDLE, ARB, GNT, DONE} state_t;

  state_t                   state, state_n;
  logic [Lvl_COLS-1:0]      mask, mask_n;
  logic [WGT_W-1:0]         cnt, cnt_n;
  logic [Lvl_COLS-1:0]      gnt_n;
  logic                     valid_n;
  logic [Lvl_COL_ADD-1:0]   yadd_n;
  logic [Lvl_COLS-1:0]      mask_req;
  logic [Lvl_COL_ADD-1:0]   pick_idx;
  logic [WGT_W-1:0]         sel_wgt;
  logic                     sel_req;

  function automatic logic [Lvl_COL_ADD-1:0] lowest_idx(input logic [Lvl_COLS-1:0] v);
    lowest_idx = '0;
    for (int c = Lvl_COLS - 1; c >= 0; c--) begin
      if (v[c]) lowest_idx = Lvl_COL_ADD'(c);
    end
  endfunction

  assign mask_req      = req_i & mask;
  // When the masked set runs dry in wrap mode the search restarts from the unmasked request vector.
  assign pick_idx      = lowest_idx((|mask_req) ? mask_req : req_i);
  assign grp_release_o = (state == DONE) || ((state == ARB) && wrap_i && (mask_req == '0));

  always_comb begin
    sel_wgt = '0;
    sel_req = 1'b0;
    for (int c = 0; c < Lvl_COLS; c++) begin
      if (gnt_o[c]) begin
        sel_wgt = wgt_i[c*WGT_W +: WGT_W];
        sel_req = req_i[c];
      end
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask;
    cnt_n   = cnt;
    gnt_n   = gnt_o;
    valid_n = gnt_valid_o;
    yadd_n  = yadd_o;
    if (!enable_i) begin
      state_n = IDLE;
      mask_n  = '1;
      cnt_n   = '0;
      gnt_n   = '0;
      valid_n = 1'b0;
      yadd_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          mask_n  = '1;
          cnt_n   = '0;
          state_n = ARB;
        end
        ARB: begin
          if ((|mask_req) || (wrap_i && (|req_i))) begin
            gnt_n   = Lvl_COLS'(1) << pick_idx;
            yadd_n  = pick_idx;
            valid_n = 1'b1;
            state_n = GNT;
          end else if (!wrap_i) begin
            state_n = DONE;
          end
          if (!(|mask_req) && wrap_i) mask_n = '1;
        end
        GNT: begin
          if (gnt_valid_o && gnt_ready_i) begin
            if (sel_req && (cnt < sel_wgt)) begin
              cnt_n = cnt + WGT_W'(1);
            end else begin
              // Keep only columns strictly above the one just served; the top column yields an empty mask.
              cnt_n   = '0;
              mask_n  = ~(gnt_o | (gnt_o - Lvl_COLS'(1)));
              gnt_n   = '0;
              valid_n = 1'b0;
              yadd_n  = '0;
              state_n = ARB;
            end
          end
        end
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      mask        <= '1;
      cnt         <= '0;
      gnt_o       <= '0;
      gnt_valid_o <= 1'b0;
      yadd_o      <= '0;
    end else begin
      state       <= state_n;
      mask        <= mask_n;
      cnt         <= cnt_n;
      gnt_o       <= gnt_n;
      gnt_valid_o <= valid_n;
      yadd_o      <= yadd_n;
    end
  end

endmodule

// File: tb/tb_column_arbiter_wrr.sv
// Self-checking bench for column_arbiter_wrr: directed scenarios plus a randomized run
// compared against a transaction-style reference model.
module tb_column_arbiter_wrr;

  localparam int COLS = 8;
  localparam int ADD  = 3;
  localparam int WW   = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              wrap = 1'b0;
  logic              ready = 1'b0;
  logic [COLS-1:0]   req = '0;
  logic [COLS*WW-1:0] wgt = '0;
  logic [COLS-1:0]   gnt;
  logic              valid;
  logic [ADD-1:0]    yadd;
  logic              grp_release;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 searching, 2 granting, 3 pass finished.
  // Eligible columns are those at or above m_floor.
  int m_phase, m_floor, m_col, m_burst;

  column_arbiter_wrr #(.Lvl_COLS(COLS), .Lvl_COL_ADD(ADD), .WGT_W(WW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .wrap_i(wrap),
    .req_i(req), .wgt_i(wgt), .gnt_o(gnt), .gnt_valid_o(valid),
    .gnt_ready_i(ready), .yadd_o(yadd), .grp_release_o(grp_release)
  );

  always #5 clk = ~clk;

  function automatic int m_first_from(int lo);
    for (int c = lo; c < COLS; c++) if (req[c]) return c;
    return -1;
  endfunction

  function automatic logic m_release();
    return (m_phase == 3) || ((m_phase == 1) && wrap && (m_first_from(m_floor) < 0));
  endfunction

  function automatic logic [COLS-1:0] col_vec(int c);
    return (c >= 0) ? (COLS'(1) << c) : '0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_floor = 0; m_col = -1; m_burst = 0;
  endtask

  task automatic model_step();
    int c, w;
    if (!reset_n || !enable) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: m_phase = 1;
      1: begin
        c = m_first_from(m_floor);
        if (c < 0 && wrap) begin
          m_floor = 0;
          c = m_first_from(0);
        end
        if (c >= 0) begin
          m_col = c; m_phase = 2;
        end else if (!wrap) begin
          m_phase = 3;
        end
      end
      2: if (ready) begin
        w = (int'(wgt) >> (WW * m_col)) & ((1 << WW) - 1);
        if (req[m_col] && m_burst < w) m_burst++;
        else begin
          m_burst = 0; m_floor = m_col + 1; m_col = -1; m_phase = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic go_idle();
    enable = 1'b0; ready = 1'b0; wrap = 1'b0; req = '0; wgt = '0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    total++;
    if ({gnt, valid, yadd, grp_release} !== '0) begin
      bad++; $display("[TB] FAIL reset_state: got gnt=%b v=%b y=%0d rel=%b want all 0", gnt, valid, yadd, grp_release);
    end
    reset_n = 1'b1;
    req = 8'h10; enable = 1'b1;
    tick(); tick();
    total++;
    if (valid !== 1'b1 || gnt !== 8'h10) begin
      bad++; $display("[TB] FAIL pre_reset_grant: got gnt=%b v=%b want 00010000 1", gnt, valid);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({gnt, valid, yadd, grp_release} !== '0) begin
      bad++; $display("[TB] FAIL mid_grant_reset: got gnt=%b v=%b y=%0d rel=%b want all 0", gnt, valid, yadd, grp_release);
    end
    @(negedge clk);
    enable = 1'b0; req = '0; reset_n = 1'b1;
    tick();
    total++;
    if ({gnt, valid, yadd, grp_release} !== '0) begin
      bad++; $display("[TB] FAIL after_reset_idle: got gnt=%b v=%b y=%0d rel=%b want all 0", gnt, valid, yadd, grp_release);
    end
  endtask

  task automatic test_single_pass();
    int exp_cols [12] = '{-1, 0, -1, 2, -1, 5, -1, 7, -1, -1, -1, -1};
    go_idle();
    req = 8'b1010_0101; ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (gnt !== col_vec(exp_cols[k]) || valid !== (exp_cols[k] >= 0) ||
          yadd !== ADD'((exp_cols[k] < 0) ? 0 : exp_cols[k]) || grp_release !== (k >= 9)) begin
        bad++; $display("[TB] FAIL single_pass[%0d]: got gnt=%b v=%b y=%0d rel=%b want col %0d rel=%b",
                        k, gnt, valid, yadd, grp_release, exp_cols[k], (k >= 9));
      end
    end
    enable = 1'b0;
    tick();
    total++;
    if (grp_release !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("[TB] FAIL single_pass_release_drop: got rel=%b v=%b want 0 0", grp_release, valid);
    end
  endtask

  task automatic test_hold();
    go_idle();
    req = 8'h10; enable = 1'b1;
    tick(); tick();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (gnt !== 8'h10 || yadd !== 3'd4 || valid !== 1'b1) begin
        bad++; $display("[TB] FAIL hold[%0d]: got gnt=%b y=%0d v=%b want 00010000 4 1", k, gnt, yadd, valid);
      end
      if (k < 3) tick();
    end
    ready = 1'b1;
    tick();
    total++;
    if (gnt !== '0 || valid !== 1'b0 || yadd !== '0) begin
      bad++; $display("[TB] FAIL hold_complete: got gnt=%b y=%0d v=%b want 0 0 0", gnt, yadd, valid);
    end
  endtask

  task automatic test_burst();
    int exp_cols [6] = '{-1, 3, 3, 3, -1, 6};
    go_idle();
    req = 8'h48; wgt = 16'h0080; ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (gnt !== col_vec(exp_cols[k]) || valid !== (exp_cols[k] >= 0) ||
          yadd !== ADD'((exp_cols[k] < 0) ? 0 : exp_cols[k])) begin
        bad++; $display("[TB] FAIL burst[%0d]: got gnt=%b v=%b y=%0d want col %0d", k, gnt, valid, yadd, exp_cols[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int   exp_cols [10] = '{-1, 0, -1, 7, -1, 0, -1, 7, -1, 0};
    logic exp_rel  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    go_idle();
    wrap = 1'b1; req = 8'b1000_0001; ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (gnt !== col_vec(exp_cols[k]) || valid !== (exp_cols[k] >= 0) || grp_release !== exp_rel[k]) begin
        bad++; $display("[TB] FAIL wrap[%0d]: got gnt=%b v=%b rel=%b want col %0d rel=%b",
                        k, gnt, valid, grp_release, exp_cols[k], exp_rel[k]);
      end
    end
  endtask

  task automatic test_enable_drop();
    go_idle();
    req = 8'h20; enable = 1'b1;
    tick(); tick();
    total++;
    if (gnt !== 8'h20 || yadd !== 3'd5 || valid !== 1'b1) begin
      bad++; $display("[TB] FAIL drop_pre: got gnt=%b y=%0d v=%b want 00100000 5 1", gnt, yadd, valid);
    end
    enable = 1'b0; ready = 1'b1;
    tick();
    total++;
    if ({gnt, valid, yadd, grp_release} !== '0) begin
      bad++; $display("[TB] FAIL drop_outputs: got gnt=%b v=%b y=%0d rel=%b want all 0", gnt, valid, yadd, grp_release);
    end
    enable = 1'b1; req = 8'b0010_0001;
    tick(); tick();
    total++;
    if (gnt !== 8'h01 || yadd !== 3'd0 || valid !== 1'b1) begin
      bad++; $display("[TB] FAIL drop_restart: got gnt=%b y=%0d v=%b want 00000001 0 1", gnt, yadd, valid);
    end
  endtask

  task automatic test_random();
    logic [COLS-1:0] exp_gnt;
    reset_n = 1'b0;
    go_idle();
    reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 39) == 0) wrap = ~wrap;
      if ($urandom_range(0, 2) != 0) req = COLS'($urandom) & COLS'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      wgt = (COLS*WW)'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #1 reset_n = 1'b0;
        model_reset();
        #1 reset_n = 1'b1;
      end
      #1;
      exp_gnt = col_vec(m_col);
      total++;
      if (gnt !== exp_gnt || valid !== (m_col >= 0) || yadd !== ADD'((m_col < 0) ? 0 : m_col)) begin
        bad++; $display("[TB] FAIL random_grant[%0d]: got gnt=%b v=%b y=%0d want gnt=%b col %0d", i, gnt, valid, yadd, exp_gnt, m_col);
      end
      total++;
      if (grp_release !== m_release()) begin
        bad++; $display("[TB] FAIL random_release[%0d]: got %b want %b", i, grp_release, m_release());
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pass();
    test_hold();
    test_burst();
    test_wrap();
    test_enable_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
